// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the SRAM BIST initiator and its helpers.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RSP,
        ST_RD_REQ,
        ST_RD_RSP,
        ST_FIN
    } bist_state_e;

    localparam int MODE_WR_BIT = 0;
    localparam int MODE_RD_BIT = 1;
    localparam int ERR_CNT_W   = 16;
    localparam int WDOG_W      = 16;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sram_bist_watchdog.sv
// Loadable down-counter; expire_o flags an exhausted count so the owner can abort a wait.
module sram_bist_watchdog #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/sram_bist_initiator.sv
// SRAM BIST initiator: walks an address range, writes pattern^idx, reads back and compares.
// Optional handshake parity checking is enabled by defining SRAM_BIST_PARITY_CHK_EN.
module sram_bist_initiator
    import sram_bist_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_WORDS  = 1024,
    parameter  int TIMEOUT    = 255,
    localparam int AW         = $clog2(NUM_WORDS),
    localparam int BW         = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [AW-1:0]         base_addr_i,
    input  logic [AW:0]           len_i,
    input  logic [DATA_WIDTH-1:0] pattern_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ERR_CNT_W-1:0]  err_count_o,
    output logic [AW-1:0]         err_addr_o,
    output logic                  timeout_o,
    output logic                  par_err_o,
    output logic                  req_o,
    output logic                  we_o,
    output logic [AW-1:0]         addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [BW-1:0]         be_o,
    output logic                  rready_o,
    output logic                  wuser_o,
    input  logic                  gnt_i,
    input  logic                  gntpar_i,
    input  logic                  rvalid_i,
    input  logic                  rvalidpar_i,
    input  logic                  ruser_i,
    input  logic [DATA_WIDTH-1:0] rdata_i
);

    bist_state_e           state_q, state_d;
    logic [AW-1:0]         base_q;
    logic [AW:0]           len_q, idx_q, idx_d, idx_inc;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] pat_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q;
    logic [AW-1:0]         err_addr_q;
    logic                  timeout_q;

    logic                  latch, clr_status, rd_mismatch, set_timeout;
    logic                  wd_en, wd_load, wd_expire;
    logic [AW:0]           addr_sum;
    logic [AW-1:0]         addr_w;
    logic [DATA_WIDTH-1:0] exp_w;

    // Both operands are below NUM_WORDS, so one conditional subtract gives the modulo.
    assign addr_sum = {1'b0, base_q} + idx_q;
    assign addr_w   = (addr_sum >= (AW+1)'(NUM_WORDS)) ? AW'(addr_sum - (AW+1)'(NUM_WORDS))
                                                       : addr_sum[AW-1:0];
    assign exp_w    = pat_q ^ DATA_WIDTH'(idx_q);
    assign idx_inc  = idx_q + (AW+1)'(1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        latch       = 1'b0;
        clr_status  = 1'b0;
        rd_mismatch = 1'b0;
        set_timeout = 1'b0;
        wd_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    latch      = 1'b1;
                    clr_status = 1'b1;
                    idx_d      = '0;
                    if ((len_i == '0) || (mode_i == 2'b00))
                        state_d = ST_FIN;
                    else if (mode_i[MODE_WR_BIT])
                        state_d = ST_WR_REQ;
                    else
                        state_d = ST_RD_REQ;
                end
            end
            ST_WR_REQ, ST_RD_REQ: begin
                if (gnt_i) begin
                    state_d = (state_q == ST_WR_REQ) ? ST_WR_RSP : ST_RD_RSP;
                end else begin
                    wd_en = 1'b1;
                    if (wd_expire) begin
                        set_timeout = 1'b1;
                        state_d     = ST_FIN;
                    end
                end
            end
            ST_WR_RSP: begin
                if (rvalid_i) begin
                    idx_d   = idx_inc;
                    state_d = ST_WR_REQ;
                    if (idx_inc == len_q) begin
                        if (mode_q[MODE_RD_BIT]) begin
                            idx_d   = '0;
                            state_d = ST_RD_REQ;
                        end else begin
                            state_d = ST_FIN;
                        end
                    end
                end else begin
                    wd_en = 1'b1;
                    if (wd_expire) begin
                        set_timeout = 1'b1;
                        state_d     = ST_FIN;
                    end
                end
            end
            ST_RD_RSP: begin
                if (rvalid_i) begin
                    rd_mismatch = (rdata_i != exp_w);
                    idx_d       = idx_inc;
                    state_d     = (idx_inc == len_q) ? ST_FIN : ST_RD_REQ;
                end else begin
                    wd_en = 1'b1;
                    if (wd_expire) begin
                        set_timeout = 1'b1;
                        state_d     = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Every state change starts a fresh wait window.
    assign wd_load = (state_d != state_q);

    sram_bist_watchdog #(.W(WDOG_W)) u_wdog (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (wd_load),
        .load_val_i (WDOG_W'(TIMEOUT - 1)),
        .en_i       (wd_en),
        .expire_o   (wd_expire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            base_q     <= '0;
            len_q      <= '0;
            mode_q     <= '0;
            pat_q      <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (latch) begin
                base_q <= base_addr_i;
                len_q  <= len_i;
                mode_q <= mode_i;
                pat_q  <= pattern_i;
            end
            if (clr_status) begin
                err_cnt_q  <= '0;
                err_addr_q <= '0;
                timeout_q  <= 1'b0;
            end else begin
                if (set_timeout)
                    timeout_q <= 1'b1;
                if (rd_mismatch) begin
                    err_cnt_q <= sat_inc(err_cnt_q);
                    if (err_cnt_q == '0)
                        err_addr_q <= addr_w;
                end
            end
        end
    end

`ifdef SRAM_BIST_PARITY_CHK_EN
    logic par_err_q;
    logic unused_ruser;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            par_err_q <= 1'b0;
        else if (clr_status)
            par_err_q <= 1'b0;
        else if (busy_o && ((gntpar_i != ~gnt_i) || (rvalidpar_i != ~rvalid_i)))
            par_err_q <= 1'b1;
    end

    assign par_err_o    = par_err_q;
    assign unused_ruser = ruser_i;
`else
    logic unused_in;
    assign par_err_o = 1'b0;
    assign unused_in = gntpar_i ^ rvalidpar_i ^ ruser_i;
`endif

    assign req_o       = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);
    assign we_o        = (state_q == ST_WR_REQ);
    assign rready_o    = (state_q == ST_WR_RSP) || (state_q == ST_RD_RSP);
    assign busy_o      = req_o || rready_o;
    assign done_o      = (state_q == ST_FIN);
    assign addr_o      = req_o ? addr_w : '0;
    assign wdata_o     = we_o ? exp_w : '0;
    assign be_o        = '1;
    assign wuser_o     = 1'b0;
    assign err_count_o = err_cnt_q;
    assign err_addr_o  = err_addr_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_sram_bist_initiator.sv
// Directed + randomized bench for sram_bist_initiator with a behavioural SRAM responder and run model.
module tb_sram_bist_initiator;

    localparam int DW = 32;
    localparam int NW = 1024;
    localparam int AW = 10;
    localparam int TO = 8;
    localparam int XW = 1 + AW + DW;

    logic            clk_i = 1'b0;
    logic            rst_i, start_i;
    logic [1:0]      mode_i;
    logic [AW-1:0]   base_addr_i;
    logic [AW:0]     len_i;
    logic [DW-1:0]   pattern_i;
    logic            busy_o, done_o, timeout_o, par_err_o;
    logic [15:0]     err_count_o;
    logic [AW-1:0]   err_addr_o;
    logic            req_o, we_o, rready_o, wuser_o;
    logic [AW-1:0]   addr_o;
    logic [DW-1:0]   wdata_o;
    logic [DW/8-1:0] be_o;
    logic            gnt_i, gntpar_i, rvalid_i, rvalidpar_i, ruser_i;
    logic [DW-1:0]   rdata_i;

    sram_bist_initiator #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .base_addr_i(base_addr_i), .len_i(len_i), .pattern_i(pattern_i),
        .busy_o(busy_o), .done_o(done_o), .err_count_o(err_count_o),
        .err_addr_o(err_addr_o), .timeout_o(timeout_o), .par_err_o(par_err_o),
        .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .be_o(be_o), .rready_o(rready_o), .wuser_o(wuser_o),
        .gnt_i(gnt_i), .gntpar_i(gntpar_i), .rvalid_i(rvalid_i),
        .rvalidpar_i(rvalidpar_i), .ruser_i(ruser_i), .rdata_i(rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Controls written only by the main sequence.
    int            stall_on = 0, stall_cyc = 0;
    bit            never_gnt = 0, flip_en = 0, par_bad = 0;
    logic [AW-1:0] flip_addr = '0;

    // Responder state, written only by the responder.
    bit [DW-1:0]     mem [NW];
    logic [XW-1:0]   xfers[$];
    logic [AW+DW-1:0] samples[$];
    int              req_num = 0, stall_left = 0;
    bit              in_req = 0, granted = 0, pend = 0;
    logic            g_we;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_wdata, rd_hold;

    // Single-outstanding SRAM: grant at the negedge, respond the cycle after the transfer.
    always @(negedge clk_i) begin
        ruser_i = 1'b0;
        if (rst_i) begin
            gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
            pend = 0; granted = 0; in_req = 0;
        end else begin
            if (granted) begin
                xfers.push_back({g_we, g_addr, (g_we ? g_wdata : {DW{1'b0}})});
                if (g_we) begin
                    mem[g_addr] = g_wdata;
                    rd_hold = '0;
                end else begin
                    rd_hold = mem[g_addr] ^ ((flip_en && g_addr == flip_addr) ? DW'(1) : DW'(0));
                end
                pend = 1; granted = 0;
            end
            rvalid_i = 1'b0;
            if (pend && rready_o) begin
                rvalid_i = 1'b1; rdata_i = rd_hold; pend = 0;
            end
            if (!busy_o) req_num = 0;
            if (!req_o) in_req = 0;
            gnt_i = 1'b0;
            if (req_o) begin
                if (!in_req) begin
                    in_req = 1; req_num++;
                    stall_left = (req_num == stall_on) ? stall_cyc : 0;
                end
                if (req_num == stall_on) samples.push_back({addr_o, wdata_o});
                if (!never_gnt) begin
                    if (stall_left > 0) stall_left--;
                    else begin
                        gnt_i = 1'b1; granted = 1; in_req = 0;
                        g_we = we_o; g_addr = addr_o; g_wdata = wdata_o;
                    end
                end
            end
        end
        gntpar_i    = par_bad ? gnt_i : ~gnt_i;
        rvalidpar_i = ~rvalid_i;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: expected transfer list, error count, first error address and latency from the rules.
    task automatic run_case(input string tag, input logic [AW-1:0] b, input int n,
                            input logic [1:0] m, input logic [DW-1:0] p,
                            input bit fe, input logic [AW-1:0] fa,
                            input int s_on, input int s_cyc, input bit hold_start);
        bit [DW-1:0]   mm [NW];
        logic [XW-1:0] exp_q[$];
        int            exp_err, exp_lat, k, x0, s0;
        logic [AW-1:0] exp_first, a;
        logic [DW-1:0] d, rd;
        mm = mem;
        exp_err = 0; exp_first = '0;
        for (int pass = 0; pass < 2; pass++) begin
            if (m[pass] && n > 0) begin
                for (int i = 0; i < n; i++) begin
                    a = AW'((int'(b) + i) % NW);
                    d = p ^ DW'(i);
                    if (pass == 0) begin
                        mm[a] = d;
                        exp_q.push_back({1'b1, a, d});
                    end else begin
                        rd = mm[a] ^ ((fe && a == fa) ? DW'(1) : DW'(0));
                        if (rd != d) begin
                            if (exp_err == 0) exp_first = a;
                            exp_err++;
                        end
                        exp_q.push_back({1'b0, a, {DW{1'b0}}});
                    end
                end
            end
        end
        exp_lat = 2 * exp_q.size() + ((s_on > 0 && s_on <= exp_q.size()) ? s_cyc : 0);
        flip_en = fe; flip_addr = fa; stall_on = s_on; stall_cyc = s_cyc;
        x0 = xfers.size(); s0 = samples.size();
        @(negedge clk_i);
        base_addr_i = b; len_i = (AW+1)'(n); mode_i = m; pattern_i = p; start_i = 1'b1;
        k = 0;
        do begin
            @(negedge clk_i);
            k++;
            if (!hold_start || k >= 3) start_i = 1'b0;
        end while (!done_o && k < 4000);
        chk({tag, " done"}, done_o, 1);
        chk({tag, " latency"}, k - 1, exp_lat);
        chk({tag, " busy_at_done"}, busy_o, 0);
        chk({tag, " err_count"}, err_count_o, exp_err);
        if (exp_err > 0) chk({tag, " err_addr"}, err_addr_o, exp_first);
        chk({tag, " timeout"}, timeout_o, 0);
        chk({tag, " n_xfers"}, xfers.size() - x0, exp_q.size());
        for (int i = 0; i < exp_q.size() && x0 + i < xfers.size(); i++)
            chk($sformatf("%s xfer%0d", tag, i), xfers[x0 + i], exp_q[i]);
        if (s_cyc > 0 && s_on <= exp_q.size()) begin
            chk({tag, " stall_samples"}, samples.size() - s0, s_cyc + 1);
            for (int i = s0; i < samples.size(); i++)
                chk($sformatf("%s stable%0d", tag, i - s0), samples[i], exp_q[s_on - 1][AW+DW-1:0]);
        end
        @(negedge clk_i);
        chk({tag, " done_one_pulse"}, done_o, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        int            k, nreq, x0, n;
        logic [AW-1:0] b;
        logic [1:0]    m;
        rst_i = 1'b1; start_i = 1'b0; mode_i = '0; base_addr_i = '0; len_i = '0; pattern_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_flags", {req_o, busy_o, done_o, timeout_o, par_err_o, we_o, rready_o, wuser_o}, 0);
        chk("rst_err_count", err_count_o, 0);
        chk("rst_err_addr", err_addr_o, 0);
        chk("rst_bus", {addr_o, wdata_o}, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        run_case("wr_rd", 10'h010, 4, 2'b11, 32'hA5A50000, 0, '0, 0, 0, 1);
        run_case("flip", 10'h010, 4, 2'b11, 32'hA5A50000, 1, 10'h012, 0, 0, 0);
        run_case("wrap", 10'd1022, 4, 2'b11, $urandom, 0, '0, 0, 0, 0);
        run_case("stall", $urandom, 4, 2'b01, $urandom, 0, '0, 2, 5, 0);
        run_case("len0", $urandom, 0, 2'b11, $urandom, 0, '0, 0, 0, 0);
        run_case("mode0", $urandom, 5, 2'b00, $urandom, 0, '0, 0, 0, 0);

        // Grant never arrives: abort after TO wait cycles.
        never_gnt = 1;
        x0 = xfers.size();
        @(negedge clk_i);
        base_addr_i = $urandom; len_i = 3; mode_i = 2'b01; start_i = 1'b1;
        k = 0; nreq = 0;
        do begin
            @(negedge clk_i);
            start_i = 1'b0; k++;
            if (req_o) nreq++;
        end while (!done_o && k < 100);
        chk("to_wait_cycles", nreq, TO);
        chk("to_flag", timeout_o, 1);
        chk("to_req_dropped", req_o, 0);
        chk("to_done", done_o, 1);
        chk("to_no_xfer", xfers.size() - x0, 0);
        @(negedge clk_i);
        chk("to_sticky", {timeout_o, done_o, busy_o}, 3'b100);
        never_gnt = 0;

        run_case("after_to", $urandom, 3, 2'b11, $urandom, 0, '0, 0, 0, 0);

        // Reset in the middle of the read pass.
        @(negedge clk_i);
        base_addr_i = $urandom; len_i = 6; mode_i = 2'b11; pattern_i = $urandom; start_i = 1'b1;
        k = 0;
        do begin
            @(negedge clk_i);
            start_i = 1'b0; k++;
        end while (!(req_o && !we_o) && k < 500);
        chk("rst_mid_rd_reached", {req_o, we_o}, 2'b10);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mid_req_busy", {req_o, busy_o, rready_o}, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        run_case("after_rst", $urandom, 4, 2'b11, $urandom, 0, '0, 0, 0, 0);

        // Parity: gntpar equal to gnt is a violation only when checking is built in.
        par_bad = 1;
        run_case("par_bad", $urandom, 2, 2'b01, $urandom, 0, '0, 0, 0, 0);
`ifdef SRAM_BIST_PARITY_CHK_EN
        chk("par_err_set", par_err_o, 1);
`else
        chk("par_err_tied", par_err_o, 0);
`endif
        par_bad = 0;
        run_case("par_ok", $urandom, 2, 2'b01, $urandom, 0, '0, 0, 0, 0);
        chk("par_err_clear", par_err_o, 0);

        for (int r = 0; r < 5; r++) begin
            m = 2'($urandom_range(1, 3));
            n = $urandom_range(1, 8);
            b = AW'($urandom);
            run_case($sformatf("rand%0d", r), b, n, m, $urandom, 1'($urandom),
                     AW'((int'(b) + $urandom_range(0, n - 1)) % NW), 0, 0, 0);
        end
        chk("be_all_ones", be_o, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
